// File: rtl/acq_peak_buffer.sv
// Acquisition buffer: normal / min-max peak / optional average capture plus trigger tap.
// Average mode (Mode=10) is built only when ACQ_AVG_EN is defined.
module acq_peak_buffer #(
   parameter int CH      = 2,
   parameter int DW      = 8,
   parameter int AW      = 12,
   parameter int TAP_DLY = 2,
   localparam int W      = 2 + CH*DW
) (
   input  logic          Mclk,
   input  logic          nRST,
   input  logic          Din_En,
   input  logic [W-1:0]  Din,
   input  logic          Wr_En,
   input  logic [1:0]    Mode,
   input  logic [15:0]   OS_Size,
   input  logic          Rd_En,
   input  logic [AW-1:0] Raddr,
   output logic [W-1:0]  Dout,
   output logic [AW-1:0] Waddr,
   output logic          Wrap,
   output logic [W-1:0]  Tap,
   output logic          Tap_Vld
);

   localparam int AD = CH*DW;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   typedef logic [CH-1:0][DW-1:0] chv_t;

   state_t        state_q;
   logic [1:0]    mode_q;
   logic [15:0]   os_q;
   logic [15:0]   cnt_q, cnt_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic          wrap_q, wrap_d;
   logic          have_q, have_d;
   chv_t          min_q, min_d, max_q, max_d;
   chv_t          hmin_q, hmin_d, hmax_q, hmax_d;

   logic [W-1:0]  mem [2**AW];
   logic [W-1:0]  dout_q;
   logic [W-1:0]  tap_q;
   logic          vld_q;
   logic [2:0]    tcnt_q;
   logic [TAP_DLY-1:0][W-1:0] sr_q;

   logic          enter, acc, we, is_peak;
   logic [1:0]    mode_e;
   logic [15:0]   os_e, cnt_e, last;
   logic [AW-1:0] waddr_e;
   logic [W-1:0]  wdata;
   chv_t          smp;

`ifdef ACQ_AVG_EN
   typedef logic [CH-1:0][DW+7:0] sum_t;
   sum_t          sum_q, sum_d;
   chv_t          avg;
   logic [3:0]    sh;
   logic [DW+7:0] tot;
   logic          is_avg;
`endif

   assign smp = chv_t'(Din[AD-1:0]);

   // The IDLE->RUN cycle already uses the freshly latched settings.
   always_comb begin
      enter   = (state_q == IDLE) && Wr_En;
      acc     = Wr_En && Din_En;
      mode_e  = enter ? Mode    : mode_q;
      os_e    = enter ? OS_Size : os_q;
      cnt_e   = enter ? '0      : cnt_q;
      waddr_e = enter ? '0      : waddr_q;
      have_d  = enter ? 1'b0    : have_q;
      wrap_d  = enter ? 1'b0    : wrap_q;
      is_peak = (mode_e == 2'b01);
      last    = (os_e == 16'd0) ? 16'd1 : os_e;
      min_d   = min_q;
      max_d   = max_q;
      hmin_d  = hmin_q;
      hmax_d  = hmax_q;
      cnt_d   = cnt_e;
      waddr_d = waddr_e;
      we      = 1'b0;
      wdata   = Din;
`ifdef ACQ_AVG_EN
      is_avg  = (mode_e == 2'b10);
      sh      = (os_e[3:0] > 4'd8) ? 4'd8 : os_e[3:0];
      sum_d   = enter ? '0 : sum_q;
      avg     = '0;
      tot     = '0;
      if (is_avg) last = (16'd1 << sh) - 16'd1;
`endif
      if (acc) begin
         if (is_peak) begin
            we    = have_d && (cnt_e <= 16'd1);
            wdata = (cnt_e == 16'd0) ? {2'b00, hmin_q}
                                     : {2'b01, hmax_q};
            for (int c = 0; c < CH; c++) begin
               if (cnt_e == 16'd0) begin
                  min_d[c] = smp[c];
                  max_d[c] = smp[c];
               end else begin
                  min_d[c] = (smp[c] < min_q[c]) ? smp[c] : min_q[c];
                  max_d[c] = (smp[c] > max_q[c]) ? smp[c] : max_q[c];
               end
            end
            if (cnt_e == last) begin
               hmin_d = min_d;
               hmax_d = max_d;
               have_d = 1'b1;
               cnt_d  = '0;
            end else begin
               cnt_d  = cnt_e + 16'd1;
            end
         end
`ifdef ACQ_AVG_EN
         else if (is_avg) begin
            for (int c = 0; c < CH; c++) begin
               tot      = sum_d[c] + {8'd0, smp[c]};
               sum_d[c] = tot;
               tot      = tot >> sh;
               avg[c]   = tot[DW-1:0];
            end
            if (cnt_e == last) begin
               we    = 1'b1;
               wdata = {Din[W-1 -: 2], avg};
               sum_d = '0;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_e + 16'd1;
            end
         end
`endif
         else begin
            we = 1'b1;
         end
      end
      if (we) begin
         waddr_d = waddr_e + 1'b1;
         if (&waddr_e) wrap_d = 1'b1;
      end
   end

   always_ff @(posedge Mclk) begin
      if (we) mem[waddr_e] <= wdata;
   end

   always_ff @(posedge Mclk or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         mode_q  <= '0;
         os_q    <= '0;
         cnt_q   <= '0;
         waddr_q <= '0;
         wrap_q  <= 1'b0;
         have_q  <= 1'b0;
         min_q   <= '0;
         max_q   <= '0;
         hmin_q  <= '0;
         hmax_q  <= '0;
         dout_q  <= '0;
         tap_q   <= '0;
         vld_q   <= 1'b0;
         tcnt_q  <= '0;
         sr_q    <= '0;
`ifdef ACQ_AVG_EN
         sum_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: if (Wr_En) begin
               state_q <= RUN;
               mode_q  <= Mode;
               os_q    <= OS_Size;
            end
            RUN: if (!Wr_En) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         cnt_q   <= cnt_d;
         waddr_q <= waddr_d;
         wrap_q  <= wrap_d;
         have_q  <= have_d;
         min_q   <= min_d;
         max_q   <= max_d;
         hmin_q  <= hmin_d;
         hmax_q  <= hmax_d;
`ifdef ACQ_AVG_EN
         sum_q   <= sum_d;
`endif
         if (Rd_En) dout_q <= mem[Raddr];
         if (Din_En) begin
            tap_q <= sr_q[TAP_DLY-1];
            for (int i = TAP_DLY-1; i > 0; i--) sr_q[i] <= sr_q[i-1];
            sr_q[0] <= Din;
            if (tcnt_q != 3'(TAP_DLY)) tcnt_q <= tcnt_q + 3'd1;
            if (tcnt_q == 3'(TAP_DLY-1)) vld_q <= 1'b1;
         end
      end
   end

   assign Dout    = dout_q;
   assign Waddr   = waddr_q;
   assign Wrap    = wrap_q;
   assign Tap     = tap_q;
   assign Tap_Vld = vld_q;

endmodule

// File: tb/tb_acq_peak_buffer.sv
// Directed bench for acq_peak_buffer (CH=2, DW=8, AW=4, TAP_DLY=2).
// Mode=10 expectations follow ACQ_AVG_EN.
module tb_acq_peak_buffer;

   localparam int W  = 18;
   localparam int AW = 4;

   logic          Mclk = 1'b0;
   logic          nRST;
   logic          Din_En;
   logic [W-1:0]  Din;
   logic          Wr_En;
   logic [1:0]    Mode;
   logic [15:0]   OS_Size;
   logic          Rd_En;
   logic [AW-1:0] Raddr;
   logic [W-1:0]  Dout;
   logic [AW-1:0] Waddr;
   logic          Wrap;
   logic [W-1:0]  Tap;
   logic          Tap_Vld;

   int checks   = 0;
   int failures = 0;

   acq_peak_buffer #(.CH(2), .DW(8), .AW(AW), .TAP_DLY(2)) dut (
      .Mclk(Mclk), .nRST(nRST), .Din_En(Din_En), .Din(Din),
      .Wr_En(Wr_En), .Mode(Mode), .OS_Size(OS_Size),
      .Rd_En(Rd_En), .Raddr(Raddr), .Dout(Dout), .Waddr(Waddr),
      .Wrap(Wrap), .Tap(Tap), .Tap_Vld(Tap_Vld)
   );

   always #5 Mclk = ~Mclk;

   task automatic do_reset();
      nRST = 1'b0; Din_En = 1'b0; Din = '0; Wr_En = 1'b0;
      Mode = '0; OS_Size = '0; Rd_En = 1'b0; Raddr = '0;
      repeat (2) @(negedge Mclk);
      nRST = 1'b1;
      @(negedge Mclk);
   endtask

   task automatic acq(input logic [W-1:0] d);
      Wr_En = 1'b1; Din_En = 1'b1; Din = d;
      @(negedge Mclk);
      Din_En = 1'b0;
   endtask

   task automatic idle();
      Wr_En = 1'b0; Din_En = 1'b0;
      @(negedge Mclk);
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [W-1:0] q);
      Rd_En = 1'b1; Raddr = a;
      @(negedge Mclk);
      Rd_En = 1'b0;
      q = Dout;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (Dout !== '0) begin failures++; $display("FAIL rst_dout got=%h exp=0", Dout); end
      checks++; if (Waddr !== '0) begin failures++; $display("FAIL rst_waddr got=%h exp=0", Waddr); end
      checks++; if (Wrap !== 1'b0) begin failures++; $display("FAIL rst_wrap got=%b exp=0", Wrap); end
      checks++; if (Tap !== '0) begin failures++; $display("FAIL rst_tap got=%h exp=0", Tap); end
      checks++; if (Tap_Vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", Tap_Vld); end
   endtask

   task automatic test_normal();
      logic [W-1:0] q;
      Mode = 2'b00; OS_Size = 16'd0;
      for (int i = 1; i <= 8; i++) acq(W'(i));
      checks++; if (Waddr !== 4'd8) begin failures++; $display("FAIL norm_waddr got=%0d exp=8", Waddr); end
      checks++; if (Tap !== 18'h00006) begin failures++; $display("FAIL norm_tap got=%h exp=00006", Tap); end
      checks++; if (Tap_Vld !== 1'b1) begin failures++; $display("FAIL norm_vld got=%b exp=1", Tap_Vld); end
      idle();
      rd(4'd3, q);
      checks++; if (q !== 18'h00004) begin failures++; $display("FAIL norm_rd3 got=%h exp=00004", q); end
      rd(4'd0, q);
      checks++; if (q !== 18'h00001) begin failures++; $display("FAIL norm_rd0 got=%h exp=00001", q); end
      rd(4'd7, q);
      checks++; if (q !== 18'h00008) begin failures++; $display("FAIL norm_rd7 got=%h exp=00008", q); end
      Raddr = 4'd5;
      @(negedge Mclk);
      checks++; if (Dout !== 18'h00008) begin failures++; $display("FAIL rd_hold got=%h exp=00008", Dout); end
   endtask

   task automatic test_rw_collision();
      logic [W-1:0] q;
      Mode = 2'b00;
      Wr_En = 1'b1; Din_En = 1'b1; Din = 18'h3ABCD;
      Rd_En = 1'b1; Raddr = 4'd0;
      @(negedge Mclk);
      Din_En = 1'b0; Rd_En = 1'b0;
      checks++; if (Dout !== 18'h00001) begin failures++; $display("FAIL coll_old got=%h exp=00001", Dout); end
      checks++; if (Waddr !== 4'd1) begin failures++; $display("FAIL coll_waddr got=%0d exp=1", Waddr); end
      idle();
      rd(4'd0, q);
      checks++; if (q !== 18'h3ABCD) begin failures++; $display("FAIL coll_new got=%h exp=3abcd", q); end
   endtask

   task automatic test_peak();
      logic [W-1:0] q;
      logic [7:0] c0 [4] = '{8'd5, 8'd9, 8'd1, 8'd7};
      logic [7:0] c1 [4] = '{8'h20, 8'h10, 8'h30, 8'h15};
      Mode = 2'b01; OS_Size = 16'd3;
      for (int i = 0; i < 4; i++) acq({2'b11, c1[i], c0[i]});
      checks++; if (Waddr !== 4'd0) begin failures++; $display("FAIL peak_w1 got=%0d exp=0", Waddr); end
      Mode = 2'b00; OS_Size = 16'd7;
      for (int i = 0; i < 4; i++) acq({2'b00, 8'h00, 8'd4});
      checks++; if (Waddr !== 4'd2) begin failures++; $display("FAIL peak_w2 got=%0d exp=2", Waddr); end
      idle();
      rd(4'd0, q);
      checks++; if (q !== 18'h01001) begin failures++; $display("FAIL peak_min got=%h exp=01001", q); end
      rd(4'd1, q);
      checks++; if (q !== 18'h13009) begin failures++; $display("FAIL peak_max got=%h exp=13009", q); end
   endtask

   task automatic test_peak_os0();
      logic [W-1:0] q;
      Mode = 2'b01; OS_Size = 16'd0;
      acq(18'h00003); acq(18'h00008);
      checks++; if (Waddr !== 4'd0) begin failures++; $display("FAIL os0_w1 got=%0d exp=0", Waddr); end
      acq(18'h00002); acq(18'h00006);
      checks++; if (Waddr !== 4'd2) begin failures++; $display("FAIL os0_w2 got=%0d exp=2", Waddr); end
      idle();
      rd(4'd0, q);
      checks++; if (q !== 18'h00003) begin failures++; $display("FAIL os0_min got=%h exp=00003", q); end
      rd(4'd1, q);
      checks++; if (q !== 18'h10008) begin failures++; $display("FAIL os0_max got=%h exp=10008", q); end
   endtask

   task automatic test_wrap();
      logic [W-1:0] q;
      Mode = 2'b11; OS_Size = 16'd0;
      for (int i = 1; i <= 17; i++) acq(18'h00100 + W'(i));
      checks++; if (Waddr !== 4'd1) begin failures++; $display("FAIL wrap_waddr got=%0d exp=1", Waddr); end
      checks++; if (Wrap !== 1'b1) begin failures++; $display("FAIL wrap_set got=%b exp=1", Wrap); end
      idle();
      checks++; if (Wrap !== 1'b1) begin failures++; $display("FAIL wrap_sticky got=%b exp=1", Wrap); end
      rd(4'd0, q);
      checks++; if (q !== 18'h00111) begin failures++; $display("FAIL wrap_rd0 got=%h exp=00111", q); end
      rd(4'd1, q);
      checks++; if (q !== 18'h00102) begin failures++; $display("FAIL wrap_rd1 got=%h exp=00102", q); end
      Wr_En = 1'b1;
      @(negedge Mclk);
      checks++; if (Wrap !== 1'b0) begin failures++; $display("FAIL wrap_clr got=%b exp=0", Wrap); end
      checks++; if (Waddr !== 4'd0) begin failures++; $display("FAIL wrap_wclr got=%0d exp=0", Waddr); end
      idle();
   endtask

   task automatic test_tap();
      do_reset();
      Din_En = 1'b1; Din = 18'h0AAAA;
      @(negedge Mclk);
      Din_En = 1'b0;
      checks++; if (Tap_Vld !== 1'b0) begin failures++; $display("FAIL tap_vld1 got=%b exp=0", Tap_Vld); end
      Din = 18'h3FFFF;
      @(negedge Mclk);
      Din_En = 1'b1; Din = 18'h0BBBB;
      @(negedge Mclk);
      Din_En = 1'b0;
      checks++; if (Tap_Vld !== 1'b1) begin failures++; $display("FAIL tap_vld2 got=%b exp=1", Tap_Vld); end
      checks++; if (Tap !== '0) begin failures++; $display("FAIL tap_b got=%h exp=0", Tap); end
      @(negedge Mclk);
      Din_En = 1'b1; Din = 18'h0CCCC;
      @(negedge Mclk);
      Din_En = 1'b0;
      checks++; if (Tap !== 18'h0AAAA) begin failures++; $display("FAIL tap_c got=%h exp=0aaaa", Tap); end
      Din_En = 1'b1; Din = 18'h0DDDD;
      @(negedge Mclk);
      Din_En = 1'b0;
      checks++; if (Tap !== 18'h0BBBB) begin failures++; $display("FAIL tap_d got=%h exp=0bbbb", Tap); end
      checks++; if (Waddr !== 4'd0) begin failures++; $display("FAIL tap_nowr got=%0d exp=0", Waddr); end
   endtask

   task automatic test_avg();
      logic [W-1:0] q;
      logic [W-1:0] exp_w3, exp_w4, exp_m0;
`ifdef ACQ_AVG_EN
      exp_w3 = 18'd0; exp_w4 = 18'd1; exp_m0 = 18'h2020B;
`else
      exp_w3 = 18'd3; exp_w4 = 18'd4; exp_m0 = 18'h0010A;
`endif
      Mode = 2'b10; OS_Size = 16'd2;
      acq(18'h0010A); acq(18'h0020B); acq(18'h0030C);
      checks++; if (18'(Waddr) !== exp_w3) begin failures++; $display("FAIL avg_w3 got=%0d exp=%0d", Waddr, exp_w3); end
      acq(18'h2050D);
      checks++; if (18'(Waddr) !== exp_w4) begin failures++; $display("FAIL avg_w4 got=%0d exp=%0d", Waddr, exp_w4); end
      idle();
      rd(4'd0, q);
      checks++; if (q !== exp_m0) begin failures++; $display("FAIL avg_word got=%h exp=%h", q, exp_m0); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] q;
      Mode = 2'b00;
      Rd_En = 1'b1; Raddr = 4'd0;
      acq(18'h12345);
      acq(18'h01111);
      #2 nRST = 1'b0;
      #1;
      checks++; if (Waddr !== '0) begin failures++; $display("FAIL mid_waddr got=%h exp=0", Waddr); end
      checks++; if (Dout !== '0) begin failures++; $display("FAIL mid_dout got=%h exp=0", Dout); end
      checks++; if (Tap !== '0) begin failures++; $display("FAIL mid_tap got=%h exp=0", Tap); end
      checks++; if (Tap_Vld !== 1'b0) begin failures++; $display("FAIL mid_vld got=%b exp=0", Tap_Vld); end
      Wr_En = 1'b0; Rd_En = 1'b0;
      @(negedge Mclk);
      nRST = 1'b1;
      @(negedge Mclk);
      Din_En = 1'b1; Din = 18'h00055;
      @(negedge Mclk);
      Din_En = 1'b0;
      checks++; if (Waddr !== '0) begin failures++; $display("FAIL mid_idle got=%h exp=0", Waddr); end
      rd(4'd0, q);
      checks++; if (q !== 18'h12345) begin failures++; $display("FAIL mid_mem got=%h exp=12345", q); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_rw_collision();
      test_peak();
      test_peak_os0();
      test_wrap();
      test_tap();
      test_avg();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
